// File: rtl/fg_config_loader_if.sv
// fg_config_loader_if: byte-wide command and readback links of the configuration loader
// data_i/valid_i/ready_o   : command/payload byte link into the loader
// rdata_o/rvalid_o/rready_i: readback byte link out of the loader
interface fg_config_loader_if;
   logic [7:0] data_i;
   logic       valid_i;
   logic       ready_o;
   logic [7:0] rdata_o;
   logic       rvalid_o;
   logic       rready_i;
   modport master (output data_i, valid_i, rready_i, input ready_o, rdata_o, rvalid_o);
   modport slave  (input data_i, valid_i, rready_i, output ready_o, rdata_o, rvalid_o);
endinterface

// File: rtl/fg_config_loader.sv
// fg_config_loader: byte-stream command decoder that loads, commits and reads back the generator configuration word
// clk_i/rst_i          : clock, synchronous active-high reset
// bus                  : command link in (data/valid/ready), readback link out (rdata/rvalid/rready)
// CR_bus_o             : active configuration word
// outputEnable_o       : generator output enable
// configUpdate_STRB_o  : one-cycle pulse when CR_bus_o takes a new value
// error_o              : one-cycle pulse on a protocol error
// busy_o               : a LOAD or READBACK frame is in progress
module fg_config_loader #(
   parameter int CONFIG_REG_BITWIDTH = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   fg_config_loader_if.slave              bus,
   output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
   output logic                           outputEnable_o,
   output logic                           configUpdate_STRB_o,
   output logic                           error_o,
   output logic                           busy_o
);
   localparam int CW = CONFIG_REG_BITWIDTH;
   localparam int BC = CW / 8;
   localparam int IW = $clog2(BC) + 1;
   localparam logic [7:0] H_LOAD = 8'hA5, H_COMMIT = 8'hC3, H_READ = 8'h96, H_EN = 8'hE1, H_DIS = 8'hE0;
   typedef enum logic [1:0] {IDLE, LOAD, READBACK} state_t;
   state_t        r_state, w_next;
   logic [IW-1:0] r_idx, w_idx;
   logic [CW-1:0] r_shadow, r_cr;
   logic          r_complete, r_oe, r_strb, r_err, r_rvalid, r_busy;
   logic [7:0]    r_rdata, w_rbyte;
   logic          w_acc, w_xfer, w_last;
   assign bus.ready_o         = r_state != READBACK;
   assign bus.rdata_o         = r_rdata;
   assign bus.rvalid_o        = r_rvalid;
   assign CR_bus_o            = r_cr;
   assign outputEnable_o      = r_oe;
   assign configUpdate_STRB_o = r_strb;
   assign error_o             = r_err;
   assign busy_o              = r_busy;
   assign w_acc  = bus.valid_i && bus.ready_o;
   assign w_xfer = r_rvalid && bus.rready_i;
   assign w_last = r_idx == IW'(BC - 1);
   // Index is held at 0 in IDLE so every frame starts from byte 0.
   always_comb begin
      w_next  = r_state;
      w_idx   = r_idx;
      w_rbyte = '0;
      unique case (r_state)
         IDLE: begin
            w_idx  = '0;
            w_next = !w_acc ? IDLE : bus.data_i == H_LOAD ? LOAD : bus.data_i == H_READ ? READBACK : IDLE;
         end
         LOAD: begin
            w_idx  = w_acc ? (w_last ? '0 : r_idx + 1'b1) : r_idx;
            w_next = w_acc && w_last ? IDLE : LOAD;
         end
         READBACK: begin
            w_idx  = w_xfer ? (w_last ? '0 : r_idx + 1'b1) : r_idx;
            w_next = w_xfer && w_last ? IDLE : READBACK;
         end
         default: w_next = IDLE;
      endcase
      for (int k = 0; k < BC; k++)
         if (w_idx == IW'(k)) w_rbyte = r_cr[CW-1-8*k -: 8];
   end
   // Readback byte is registered from the next index so it is valid the cycle after 0x96 is accepted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_shadow   <= '0;
         r_cr       <= '0;
         r_complete <= 1'b0;
         r_oe       <= 1'b0;
         r_strb     <= 1'b0;
         r_err      <= 1'b0;
         r_rvalid   <= 1'b0;
         r_busy     <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_state  <= w_next;
         r_idx    <= w_idx;
         r_strb   <= 1'b0;
         r_err    <= 1'b0;
         r_rvalid <= w_next == READBACK;
         r_busy   <= w_next != IDLE;
         r_rdata  <= w_next == READBACK ? w_rbyte : '0;
         if (r_state == IDLE && w_acc) begin
            if (bus.data_i == H_LOAD) r_complete <= 1'b0;
            else if (bus.data_i == H_COMMIT) begin
               if (r_complete) begin
                  r_cr   <= r_shadow;
                  r_strb <= 1'b1;
               end else r_err <= 1'b1;
            end
            else if (bus.data_i == H_EN) r_oe <= 1'b1;
            else if (bus.data_i == H_DIS) r_oe <= 1'b0;
            else if (bus.data_i != H_READ) r_err <= 1'b1;
         end
         if (r_state == LOAD && w_acc) begin
            for (int k = 0; k < BC; k++)
               if (r_idx == IW'(k)) r_shadow[CW-1-8*k -: 8] <= bus.data_i;
            if (w_last) r_complete <= 1'b1;
         end
      end
   end
endmodule
